// File: rtl/btn_conditioner_pkg.sv
// Shared button-index map for the conditioner and the calculator top-level.
// btn_raw / btn_level / btn_pulse bit positions: c, l, u, r, d.
package btn_conditioner_pkg;

  localparam int unsigned IDX_BTNC  = 0;
  localparam int unsigned IDX_BTNL  = 1;
  localparam int unsigned IDX_BTNU  = 2;
  localparam int unsigned IDX_BTNR  = 3;
  localparam int unsigned IDX_BTND  = 4;
  localparam int unsigned BTN_COUNT = IDX_BTND + 1;

  // Nominal settle window: 10 ms at 100 MHz.
  localparam int unsigned DEBOUNCE_DEFAULT = 1000000;
  localparam int unsigned CNT_W_DEFAULT    = 24;

endpackage

// File: rtl/btn_conditioner_debounce_1b.sv
// Single-channel button conditioner: 2-FF synchroniser, stability counter,
// debounced level register and press pulse.
// Ports:
//   clk       system clock (rising edge)
//   rst       synchronous active-high reset
//   btn_raw   raw asynchronous button input
//   btn_level debounced state, 1 = pressed (flop output)
//   btn_pulse one-cycle pulse when btn_level rises (flop output)
module btn_debounce_1b #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;

  logic             w_stable_next;
  logic [CNT_W-1:0] w_cnt_next;

  // Count consecutive cycles where the synchronised input disagrees with the
  // accepted state; any agreement restarts the window.
  always_comb begin
    w_stable_next = r_stable;
    w_cnt_next    = '0;
    if (r_s2 != r_stable) begin
      if (r_cnt == CNT_LAST) begin
        w_stable_next = r_s2;
      end else begin
        w_cnt_next = r_cnt + CNT_W'(1);
      end
    end
  end

  // Synchroniser, counter, stable state and rising-edge pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_pulse  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1     <= btn_raw;
      r_s2     <= r_s1;
      r_stable <= w_stable_next;
      r_pulse  <= w_stable_next & ~r_stable;
      r_cnt    <= w_cnt_next;
    end
  end

  assign btn_level = r_stable;
  assign btn_pulse = r_pulse;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button front end: one independent debounce channel per button.
// Ports:
//   clk       system clock (rising edge)
//   rst       synchronous active-high reset
//   btn_raw   raw buttons, bit map from btn_conditioner_pkg
//   btn_level debounced levels (opcode select)
//   btn_pulse one-cycle press pulses (accumulator clear/load)
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned NUM_BTN         = BTN_COUNT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse
);

  // No shared state between channels: simultaneous presses pulse together.
  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_debounce_1b #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_deb (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw[g]),
      .btn_level (btn_level[g]),
      .btn_pulse (btn_pulse[g])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner with a short debounce window.
module tb_btn_conditioner;

  localparam int unsigned NB = 5;
  localparam int unsigned DC = 4;
  localparam int unsigned CW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_pulse;

  always #5 clk = ~clk;

  btn_conditioner #(
    .NUM_BTN         (NB),
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse)
  );

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  // Reference: what the debouncer sees at an edge is the raw value sampled two
  // edges earlier (zero right after reset). A channel's level flips once it has
  // seen DC consecutive edges of the opposite value; a rise also pulses.
  logic [NB-1:0] q_hist[$];
  logic [NB-1:0] m_level = '0;
  logic [NB-1:0] m_pulse = '0;
  int            m_run[NB];

  always @(posedge clk) begin
    logic [NB-1:0] seen;
    edge_n = edge_n + 1;
    if (rst) begin
      q_hist.delete();
      q_hist.push_back('0);
      q_hist.push_back('0);
      m_level = '0;
      m_pulse = '0;
      for (int c = 0; c < NB; c++) m_run[c] = 0;
    end else begin
      seen = (q_hist.size() >= 2) ? q_hist[0] : '0;
      if (q_hist.size() > 0) void'(q_hist.pop_front());
      q_hist.push_back(btn_raw);
      m_pulse = '0;
      for (int c = 0; c < NB; c++) begin
        if (seen[c] != m_level[c]) m_run[c] = m_run[c] + 1;
        else                       m_run[c] = 0;
        if (m_run[c] == int'(DC)) begin
          m_level[c] = seen[c];
          m_pulse[c] = seen[c];
          m_run[c]   = 0;
        end
      end
    end
  end

  int pc[NB];

  // Advance one edge, compare against the reference, and tally pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    checks = checks + 1;
    if (btn_level !== m_level) begin
      errors = errors + 1;
      $display("FAIL level edge=%0d got=%b exp=%b", edge_n, btn_level, m_level);
    end
    checks = checks + 1;
    if (btn_pulse !== m_pulse) begin
      errors = errors + 1;
      $display("FAIL pulse edge=%0d got=%b exp=%b", edge_n, btn_pulse, m_pulse);
    end
    for (int c = 0; c < NB; c++) pc[c] = pc[c] + int'(btn_pulse[c]);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr_pc();
    for (int c = 0; c < NB; c++) pc[c] = 0;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  initial begin
    int lvl_seen;
    clr_pc();
    // Reset with all buttons held.
    rst = 1'b1; btn_raw = '1;
    ticks(2);
    chk("rst_level", int'(btn_level), 0);
    chk("rst_pulse", int'(btn_pulse), 0);
    rst = 1'b0;
    ticks(5);
    chk("held_rst_lvl_e5", int'(btn_level), 0);
    tick();
    chk("held_rst_lvl_e6", int'(btn_level), 31);
    chk("held_rst_pls_e6", int'(btn_pulse), 31);
    tick();
    chk("held_rst_pls_e7", int'(btn_pulse), 0);
    btn_raw = '0;
    ticks(8);
    chk("all_released", int'(btn_level), 0);

    // Clean press on btnd.
    clr_pc();
    btn_raw[4] = 1'b1;
    ticks(5);
    chk("press_lvl_e5", int'(btn_level[4]), 0);
    tick();
    chk("press_lvl_e6", int'(btn_level[4]), 1);
    chk("press_pls_e6", int'(btn_pulse[4]), 1);
    ticks(14);
    chk("press_pls_count", pc[4], 1);
    chk("press_lvl_held", int'(btn_level[4]), 1);
    btn_raw[4] = 1'b0;
    ticks(8);

    // Bounce on btnu.
    clr_pc();
    lvl_seen = 0;
    begin
      logic [4:0] seq;
      seq = 5'b01101;
      for (int i = 0; i < 5; i++) begin
        btn_raw[2] = seq[i];
        tick();
        lvl_seen = lvl_seen + int'(btn_level[2]);
      end
    end
    btn_raw[2] = 1'b1;
    ticks(5);
    lvl_seen = lvl_seen + int'(btn_level[2]);
    chk("bounce_quiet", lvl_seen + pc[2], 0);
    tick();
    chk("bounce_lvl_e6", int'(btn_level[2]), 1);
    chk("bounce_pls_count", pc[2], 1);
    btn_raw[2] = 1'b0;
    ticks(8);

    // Short glitch on btnc.
    clr_pc();
    lvl_seen = 0;
    btn_raw[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); lvl_seen += int'(btn_level[0]); end
    btn_raw[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); lvl_seen += int'(btn_level[0]); end
    chk("glitch_level", lvl_seen, 0);
    chk("glitch_pulse", pc[0], 0);

    // Release and re-press on btnl.
    clr_pc();
    btn_raw[1] = 1'b1; ticks(8);
    btn_raw[1] = 1'b0; ticks(10);
    chk("release_lvl", int'(btn_level[1]), 0);
    chk("release_no_pulse", pc[1], 1);
    btn_raw[1] = 1'b1; ticks(8);
    chk("repress_count", pc[1], 2);
    btn_raw[1] = 1'b0; ticks(8);

    // Reset on edge 4 of a btnr press; button stays held through it.
    clr_pc();
    btn_raw[3] = 1'b1; ticks(3);
    rst = 1'b1; tick();
    rst = 1'b0; ticks(4);
    chk("midrst_lvl", int'(btn_level[3]), 0);
    chk("midrst_pls", pc[3], 0);
    ticks(2);
    chk("midrst_repress_lvl", int'(btn_level[3]), 1);
    chk("midrst_repress_pls", pc[3], 1);
    btn_raw[3] = 1'b0; ticks(8);

    // Random bouncing with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < NB; c++)
        if ($urandom_range(7, 0) == 0) btn_raw[c] = ~btn_raw[c];
      rst = ($urandom_range(299, 0) == 0);
      tick();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
